// File: rtl/alu_operand_loader_if.sv
// Nibble-in / operand-pair-out handshake bundle for alu_operand_loader.
// Optional parity signals exist only when ALU_LOAD_PARITY_EN is defined.
interface alu_operand_loader_if;
    logic [3:0] nib_in;
    logic       nib_valid;
    logic       nib_ready;
    logic [3:0] A;
    logic [3:0] B;
    logic       op_valid;
    logic       op_ready;
    logic [7:0] op_count;
`ifdef ALU_LOAD_PARITY_EN
    logic       nib_par;
    logic       par_err;
`endif

    // Loader side
    modport slave (
        input  nib_in,
        input  nib_valid,
        input  op_ready,
`ifdef ALU_LOAD_PARITY_EN
        input  nib_par,
        output par_err,
`endif
        output nib_ready,
        output A,
        output B,
        output op_valid,
        output op_count
    );

    // Upstream source plus downstream consumer side
    modport master (
        output nib_in,
        output nib_valid,
        output op_ready,
`ifdef ALU_LOAD_PARITY_EN
        output nib_par,
        input  par_err,
`endif
        input  nib_ready,
        input  A,
        input  B,
        input  op_valid,
        input  op_count
    );
endinterface

// File: rtl/alu_operand_loader.sv
// Collects two nibbles into an {A,B} operand pair and presents it with a valid/ready handshake.
// Optional even-parity checking on incoming nibbles is enabled by defining ALU_LOAD_PARITY_EN.
module alu_operand_loader (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    alu_operand_loader_if.slave  bus
);

    typedef enum logic [1:0] {
        S_A    = 2'd0,
        S_B    = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t     r_state;
    logic [3:0] r_a;
    logic [3:0] r_b;
    logic       r_op_valid;
    logic [7:0] r_op_count;

    logic w_can_accept;
    logic w_xfer;
    logic w_consume;
    logic w_par_bad;

`ifdef ALU_LOAD_PARITY_EN
    logic r_par_err;
    // Even parity: nibble bits plus parity bit must XOR to zero
    assign w_par_bad   = ^{bus.nib_in, bus.nib_par};
    assign bus.par_err = r_par_err;
`else
    assign w_par_bad   = 1'b0;
`endif

    // Accepting in S_HOLD is only safe when the held pair leaves on the same edge
    assign w_can_accept  = !flush && ((r_state != S_HOLD) || bus.op_ready);
    assign w_xfer        = bus.nib_valid && w_can_accept;
    assign w_consume     = r_op_valid && bus.op_ready;
    assign bus.nib_ready = w_can_accept && !rst;

    assign bus.A        = r_a;
    assign bus.B        = r_b;
    assign bus.op_valid = r_op_valid;
    assign bus.op_count = r_op_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_A;
            r_a        <= 4'h0;
            r_b        <= 4'h0;
            r_op_valid <= 1'b0;
            r_op_count <= 8'h00;
`ifdef ALU_LOAD_PARITY_EN
            r_par_err  <= 1'b0;
`endif
        end else if (flush) begin
            r_state    <= S_A;
            r_op_valid <= 1'b0;
`ifdef ALU_LOAD_PARITY_EN
            r_par_err  <= 1'b0;
`endif
        end else begin
            if (w_consume) begin
                r_op_count <= r_op_count + 8'd1;
                r_state    <= S_A;
                r_op_valid <= 1'b0;
            end
            if (w_xfer) begin
                if (w_par_bad) begin
                    // Bad nibble drops any half-built pair; A/B keep their values
                    r_state    <= S_A;
                    r_op_valid <= 1'b0;
`ifdef ALU_LOAD_PARITY_EN
                    r_par_err  <= 1'b1;
`endif
                end else begin
                    unique case (r_state)
                        S_A, S_HOLD: begin
                            r_a     <= bus.nib_in;
                            r_state <= S_B;
                        end
                        S_B: begin
                            r_b        <= bus.nib_in;
                            r_state    <= S_HOLD;
                            r_op_valid <= 1'b1;
                        end
                        default: begin
                            r_state    <= S_A;
                            r_op_valid <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

endmodule
